dcache_axi_bridge: RTL and testbench

//  Memory-side responder for the data cache's miss/write-through request port. Accepts one

---
 rtl/dcache_axi_bridge.sv | 178 +++++++++++++++++
 tb/tb_dcache_axi_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_axi_bridge.sv
// Single-outstanding bridge from the data cache miss/write-through port to AXI4.
// One beat per request; read data and write completion are reported with a one-cycle dok.
module dcache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // cache side
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dok,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_D  = 3'd2,
        S_WR_AW = 3'd3,
        S_WR_B  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:2] addr_q, addr_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        dok_q, dok_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    // Response code is not propagated and the beat is always word aligned.
    logic unused_bits;
    assign unused_bits = ^{rresp, addr[1:0]};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        dok_d     = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr[31:2];
                    wen_d   = wen;
                    wdata_d = wdata;
                    if (wen == 4'b0000) begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_A;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_AW;
                    end
                end
            end
            S_RD_A: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                if (rvalid && rready_q) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata_axi;
                    dok_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_WR_AW: begin
                // AW and W complete independently; leave once neither is still pending.
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: begin
                if (bvalid && bready_q) begin
                    bready_d = 1'b0;
                    dok_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // Cache still holds req here; it must not start a new transaction.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wen_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            dok_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            dok_q     <= dok_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign rdata     = rdata_q;
    assign dok       = dok_q;
    assign arid      = AXI_ID;
    assign araddr    = {addr_q, 2'b00};
    assign arsize    = 3'b010;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awid      = AXI_ID;
    assign awaddr    = {addr_q, 2'b00};
    assign awsize    = 3'b010;
    assign awvalid   = awvalid_q;
    assign wdata_axi = wdata_q;
    assign wstrb     = wen_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Bench for dcache_axi_bridge: randomised AXI slave timing against a transaction-level model.
module tb_dcache_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        req;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wen;
    logic        dok;
    logic [3:0]  arid, awid, wstrb;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp;

    dcache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .req(req), .addr(addr), .wen(wen), .wdata(wdata), .rdata(rdata), .dok(dok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int n_cmp = 0, n_bad = 0, dok_cnt = 0, n_txn = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: idle, one outstanding request, one completion cycle.
    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mst_t;
    mst_t        m_st;
    logic        m_on = 1'b0;
    logic        m_ar, m_aw, m_w;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [3:0]  m_wen;

    always @(posedge clk) begin
        if (!resetn) begin
            m_on <= 1'b1; m_st <= M_IDLE;
            m_ar <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0;
            m_rdata <= '0; m_addr <= '0; m_wdata <= '0; m_wen <= '0;
        end else if (m_on) begin
            case (m_st)
                M_IDLE: if (req) begin
                    m_st <= M_BUSY; m_addr <= addr; m_wen <= wen; m_wdata <= wdata;
                end
                M_BUSY: if (m_wen == 4'h0) begin
                    if (!m_ar && arvalid && arready) m_ar <= 1'b1;
                    if (m_ar && rvalid && rready) begin m_rdata <= rdata_axi; m_st <= M_DONE; end
                end else begin
                    if (!m_aw && awvalid && awready) m_aw <= 1'b1;
                    if (!m_w && wvalid && wready)    m_w  <= 1'b1;
                    if (m_aw && m_w && bvalid && bready) m_st <= M_DONE;
                end
                default: begin
                    m_st <= M_IDLE; m_ar <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("dok", dok, m_st == M_DONE);
            chk("rdata", rdata, m_rdata);
            chk("arvalid", arvalid, m_st == M_BUSY && m_wen == 4'h0 && !m_ar);
            chk("rready", rready, m_st == M_BUSY && m_wen == 4'h0 && m_ar);
            chk("awvalid", awvalid, m_st == M_BUSY && m_wen != 4'h0 && !m_aw);
            chk("wvalid", wvalid, m_st == M_BUSY && m_wen != 4'h0 && !m_w);
            chk("bready", bready, m_st == M_BUSY && m_wen != 4'h0 && m_aw && m_w);
            chk("araddr", araddr, {m_addr[31:2], 2'b00});
            chk("awaddr", awaddr, {m_addr[31:2], 2'b00});
            chk("wstrb", wstrb, m_wen);
            chk("wdata_axi", wdata_axi, m_wdata);
            chk("ids", {arid, awid}, 8'h11);
            chk("sizes", {arsize, awsize}, 6'b010010);
            if (dok === 1'b1) dok_cnt++;
        end
    end

    // Drives one request and acts as AXI slave with the given delays (cycles from req).
    task automatic run_txn(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                           input int d1, input int d2, input int d3, input logic [31:0] rd,
                           input bit hold, output int lat, output logic [31:0] dok_rd);
        int t, c2;
        bit done;
        t = 0; c2 = 0; done = 1'b0;
        req = 1'b1; addr = a; wen = be; wdata = d;
        while (!done && t < 200) begin
            if (be == 4'h0) begin
                arready = !m_ar && t >= d1;
                if (m_ar) begin rvalid = (c2 >= d2); c2++; end
                rdata_axi = rvalid ? rd : $urandom;
            end else begin
                awready = !m_aw && t >= d1;
                wready  = !m_w && t >= d2;
                if (m_aw && m_w) begin bvalid = (c2 >= d3); c2++; end
            end
            @(posedge clk); #1;
            t++;
            done = (m_st == M_DONE);
        end
        chk("txn_done", done, 1'b1);
        n_txn++;
        lat = t;
        dok_rd = rdata;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        @(posedge clk); #1;
        if (!hold) begin
            req = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rdv, rd, ra;
        logic [3:0]  be;
        req = 1'b0; addr = '0; wen = '0; wdata = '0;
        arready = 1'b0; rdata_axi = '0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valids", {dok, arvalid, rready, awvalid, wvalid, bready}, 6'b0);
        chk("rst_araddr", araddr, 32'h0);

        // Read with delayed arready and rvalid
        run_txn(32'h1FC0_0104, 4'h0, 32'h0, 2, 3, 0, 32'hDEADBEEF, 1'b0, lat, rdv);
        chk("t1_rdata_at_dok", rdv, 32'hDEADBEEF);
        chk("t1_araddr", araddr, 32'h1FC0_0104);

        // Write, wready ahead of awready; read data must survive it
        run_txn(32'h0000_2003, 4'b0011, 32'h12345678, 4, 2, 1, 32'h0, 1'b0, lat, rdv);
        chk("t2_awaddr", awaddr, 32'h0000_2000);
        chk("t2_wstrb", wstrb, 4'b0011);
        chk("t2_wdata", wdata_axi, 32'h12345678);
        chk("t6_rdata_kept", rdata, 32'hDEADBEEF);

        // Zero-wait write and read: dok three cycles after req
        run_txn(32'h0000_8000, 4'hF, 32'hA5A5_5A5A, 0, 0, 0, 32'h0, 1'b0, lat, rdv);
        chk("t3_wr_latency", lat, 3);
        run_txn(32'h0000_9004, 4'h0, 32'h0, 0, 0, 0, 32'h1111_2222, 1'b1, lat, rdv);
        chk("rd_latency", lat, 3);

        // req held through dok, then back-to-back read
        run_txn(32'h0000_A008, 4'h0, 32'h0, 1, 1, 0, 32'h0BADF00D, 1'b0, lat, rdv);
        chk("t6_rdata_new", rdv, 32'h0BADF00D);

        // Reset while waiting for read data; later rvalid must be ignored
        req = 1'b1; addr = 32'h0000_4440; wen = 4'h0; arready = 1'b1;
        for (int i = 0; i < 50 && !m_ar; i++) begin @(posedge clk); #1; end
        chk("t5_reach_rd_d", m_ar, 1'b1);
        arready = 1'b0; resetn = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        chk("t5_outputs", {arvalid, rready, dok}, 3'b000);
        chk("t5_rdata", rdata, 32'h0);
        resetn = 1'b1; rvalid = 1'b1; rdata_axi = 32'hCAFE_F00D;
        repeat (3) begin @(posedge clk); #1; end
        chk("t5_late_rdata", rdata, 32'h0);
        chk("t5_late_dok", dok, 1'b0);
        rvalid = 1'b0;

        for (int k = 0; k < 40; k++) begin
            be = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            rd = $urandom;
            ra = $urandom;
            run_txn(ra, be, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), rd, bit'($urandom_range(0, 1)), lat, rdv);
            if (be == 4'h0) chk("rand_rdata", rdv, rd);
        end
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dok_count", dok_cnt, n_txn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
